// File: rtl/frame_sequencer.sv
// Frame sequencer: streams voxels to the shader array for rasterization, sweeps the
// palette for shading, then reads the shaded pixels back into the framebuffer.
module frame_sequencer #(
  parameter int COORD_BITS      = 8,
  parameter int PALETTE_BITS    = 8,
  parameter int PIXEL_BITS      = 8,
  parameter int ROW_BITS        = 8,
  parameter int COL_BITS        = 8,
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int VOXEL_ADDR_BITS = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  start_i,
  input  logic [VOXEL_ADDR_BITS-1:0]            num_voxels_i,
  output logic [VOXEL_ADDR_BITS-1:0]            voxel_addr_o,
  input  logic [3*COORD_BITS+PALETTE_BITS-1:0]  voxel_rdata_i,
  output logic [PALETTE_BITS-1:0]               palette_addr_o,
  input  logic [PIXEL_BITS-1:0]                 palette_rdata_i,
  output logic [COORD_BITS-1:0]                 voxel_x_o,
  output logic [COORD_BITS-1:0]                 voxel_y_o,
  output logic [COORD_BITS-1:0]                 voxel_z_o,
  output logic [PALETTE_BITS-1:0]               voxel_id_o,
  output logic [PIXEL_BITS-1:0]                 palette_entry_o,
  output logic                                  do_rasterize_o,
  output logic                                  do_shade_o,
  input  logic                                  rasterizing_done_i,
  input  logic                                  shading_done_i,
  output logic [ROW_BITS-1:0]                   row_o,
  output logic [COL_BITS-1:0]                   col_o,
  input  logic [PIXEL_BITS-1:0]                 pixel_i,
  output logic                                  fb_valid_o,
  input  logic                                  fb_ready_i,
  output logic [ROW_BITS+COL_BITS-1:0]          fb_addr_o,
  output logic [PIXEL_BITS-1:0]                 fb_data_o,
  output logic                                  busy_o,
  output logic                                  frame_done_o
);

  localparam int REC_W = 3*COORD_BITS + PALETTE_BITS;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_RAST_FETCH  = 3'd1;
  localparam logic [2:0] S_RASTERIZE   = 3'd2;
  localparam logic [2:0] S_SHADE_FETCH = 3'd3;
  localparam logic [2:0] S_SHADE       = 3'd4;
  localparam logic [2:0] S_RD_SET      = 3'd5;
  localparam logic [2:0] S_RD_WRITE    = 3'd6;
  localparam logic [2:0] S_DONE        = 3'd7;

  localparam logic [PALETTE_BITS:0] PAL_LAST = {1'b0, {PALETTE_BITS{1'b1}}};

  logic [2:0]                    state_q, state_d;
  logic [1:0]                    phase_q, phase_d;
  logic [1:0]                    pf_wait_q, pf_wait_d;
  logic [VOXEL_ADDR_BITS-1:0]    num_q, num_d;
  logic [VOXEL_ADDR_BITS-1:0]    vcnt_q, vcnt_d;
  logic [PALETTE_BITS:0]         pcnt_q, pcnt_d;
  logic [REC_W-1:0]              pf_vox_q, pf_vox_d;
  logic [PIXEL_BITS-1:0]         pf_pal_q, pf_pal_d;
  logic [VOXEL_ADDR_BITS-1:0]    vaddr_q, vaddr_d;
  logic [PALETTE_BITS-1:0]       paddr_q, paddr_d;
  logic [COORD_BITS-1:0]         vx_q, vx_d, vy_q, vy_d, vz_q, vz_d;
  logic [PALETTE_BITS-1:0]       vid_q, vid_d;
  logic [PIXEL_BITS-1:0]         pent_q, pent_d;
  logic                          do_rast_q, do_rast_d, do_shade_q, do_shade_d;
  logic [ROW_BITS-1:0]           row_q, row_d;
  logic [COL_BITS-1:0]           col_q, col_d;
  logic                          fb_valid_q, fb_valid_d;
  logic [ROW_BITS+COL_BITS-1:0]  fb_addr_q, fb_addr_d;
  logic [PIXEL_BITS-1:0]         fb_data_q, fb_data_d;
  logic                          busy_q, busy_d, fdone_q, fdone_d;

  // The prefetch read lands on rdata one cycle before it is latched; a done arriving
  // in that cycle takes the record straight from the RAM port.
  logic [REC_W-1:0]      vrec_nxt;
  logic [PIXEL_BITS-1:0] pal_nxt;
  logic                  pf_usable, last_vox, last_pal;

  assign vrec_nxt  = (pf_wait_q == 2'd1) ? voxel_rdata_i : pf_vox_q;
  assign pal_nxt   = (pf_wait_q == 2'd1) ? palette_rdata_i : pf_pal_q;
  assign pf_usable = (pf_wait_q != 2'd2);
  assign last_vox  = (vcnt_q == num_q - VOXEL_ADDR_BITS'(1));
  assign last_pal  = (pcnt_q == PAL_LAST);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pf_wait_d  = (pf_wait_q != 2'd0) ? pf_wait_q - 2'd1 : 2'd0;
    num_d      = num_q;
    vcnt_d     = vcnt_q;
    pcnt_d     = pcnt_q;
    pf_vox_d   = pf_vox_q;
    pf_pal_d   = pf_pal_q;
    vaddr_d    = vaddr_q;
    paddr_d    = paddr_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    vz_d       = vz_q;
    vid_d      = vid_q;
    pent_d     = pent_q;
    do_rast_d  = do_rast_q;
    do_shade_d = do_shade_q;
    row_d      = row_q;
    col_d      = col_q;
    fb_valid_d = fb_valid_q;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    busy_d     = busy_q;
    fdone_d    = fdone_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_d   = num_voxels_i;
          phase_d = 2'd0;
          busy_d  = 1'b1;
          if (num_voxels_i != '0) begin
            state_d = S_RAST_FETCH;
            vaddr_d = '0;
            vcnt_d  = '0;
          end else begin
            state_d = S_SHADE_FETCH;
            paddr_d = '0;
            pcnt_d  = '0;
          end
        end
      end
      S_RAST_FETCH: begin
        case (phase_q)
          2'd0: begin
            vaddr_d = VOXEL_ADDR_BITS'(1);
            phase_d = 2'd1;
          end
          2'd1: begin
            {vx_d, vy_d, vz_d, vid_d} = voxel_rdata_i;
            phase_d = 2'd2;
          end
          default: begin
            pf_vox_d  = voxel_rdata_i;
            do_rast_d = 1'b1;
            state_d   = S_RASTERIZE;
          end
        endcase
      end
      S_RASTERIZE: begin
        if (pf_wait_q == 2'd1) pf_vox_d = voxel_rdata_i;
        if (rasterizing_done_i) begin
          if (last_vox) begin
            do_rast_d = 1'b0;
            state_d   = S_SHADE_FETCH;
            paddr_d   = '0;
            pcnt_d    = '0;
            phase_d   = 2'd0;
          end else if (pf_usable) begin
            {vx_d, vy_d, vz_d, vid_d} = vrec_nxt;
            vcnt_d    = vcnt_q + VOXEL_ADDR_BITS'(1);
            vaddr_d   = vcnt_q + VOXEL_ADDR_BITS'(2);
            pf_wait_d = 2'd2;
          end
        end
      end
      S_SHADE_FETCH: begin
        case (phase_q)
          2'd0: begin
            paddr_d = PALETTE_BITS'(1);
            phase_d = 2'd1;
          end
          2'd1: begin
            pent_d  = palette_rdata_i;
            vid_d   = '0;
            phase_d = 2'd2;
          end
          default: begin
            pf_pal_d   = palette_rdata_i;
            do_shade_d = 1'b1;
            state_d    = S_SHADE;
          end
        endcase
      end
      S_SHADE: begin
        if (pf_wait_q == 2'd1) pf_pal_d = palette_rdata_i;
        if (shading_done_i) begin
          if (last_pal) begin
            do_shade_d = 1'b0;
            state_d    = S_RD_SET;
            row_d      = '0;
            col_d      = '0;
          end else if (pf_usable) begin
            pent_d    = pal_nxt;
            vid_d     = pcnt_q[PALETTE_BITS-1:0] + PALETTE_BITS'(1);
            pcnt_d    = pcnt_q + (PALETTE_BITS+1)'(1);
            paddr_d   = pcnt_q[PALETTE_BITS-1:0] + PALETTE_BITS'(2);
            pf_wait_d = 2'd2;
          end
        end
      end
      S_RD_SET: begin
        fb_data_d  = pixel_i;
        fb_addr_d  = {row_q, col_q};
        fb_valid_d = 1'b1;
        state_d    = S_RD_WRITE;
      end
      S_RD_WRITE: begin
        if (fb_ready_i) begin
          fb_valid_d = 1'b0;
          state_d    = S_RD_SET;
          if (col_q == COL_BITS'(NUM_COLS-1)) begin
            col_d = '0;
            if (row_q == ROW_BITS'(NUM_ROWS-1)) begin
              row_d   = '0;
              state_d = S_DONE;
              fdone_d = 1'b1;
            end else begin
              row_d = row_q + ROW_BITS'(1);
            end
          end else begin
            col_d = col_q + COL_BITS'(1);
          end
        end
      end
      default: begin
        fdone_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      pf_wait_q  <= '0;
      num_q      <= '0;
      vcnt_q     <= '0;
      pcnt_q     <= '0;
      pf_vox_q   <= '0;
      pf_pal_q   <= '0;
      vaddr_q    <= '0;
      paddr_q    <= '0;
      vx_q       <= '0;
      vy_q       <= '0;
      vz_q       <= '0;
      vid_q      <= '0;
      pent_q     <= '0;
      do_rast_q  <= 1'b0;
      do_shade_q <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      fb_valid_q <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      busy_q     <= 1'b0;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pf_wait_q  <= pf_wait_d;
      num_q      <= num_d;
      vcnt_q     <= vcnt_d;
      pcnt_q     <= pcnt_d;
      pf_vox_q   <= pf_vox_d;
      pf_pal_q   <= pf_pal_d;
      vaddr_q    <= vaddr_d;
      paddr_q    <= paddr_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      vz_q       <= vz_d;
      vid_q      <= vid_d;
      pent_q     <= pent_d;
      do_rast_q  <= do_rast_d;
      do_shade_q <= do_shade_d;
      row_q      <= row_d;
      col_q      <= col_d;
      fb_valid_q <= fb_valid_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      busy_q     <= busy_d;
      fdone_q    <= fdone_d;
    end
  end

  assign voxel_addr_o    = vaddr_q;
  assign palette_addr_o  = paddr_q;
  assign voxel_x_o       = vx_q;
  assign voxel_y_o       = vy_q;
  assign voxel_z_o       = vz_q;
  assign voxel_id_o      = vid_q;
  assign palette_entry_o = pent_q;
  assign do_rasterize_o  = do_rast_q;
  assign do_shade_o      = do_shade_q;
  assign row_o           = row_q;
  assign col_o           = col_q;
  assign fb_valid_o      = fb_valid_q;
  assign fb_addr_o       = fb_addr_q;
  assign fb_data_o       = fb_data_q;
  assign busy_o          = busy_q;
  assign frame_done_o    = fdone_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench for frame_sequencer: RAM models, a cycle-stepped shader/framebuffer
// responder, and an expected-frame model built from the voxel list, palette and pixel map.
module tb_frame_sequencer;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int NPAL = 256;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  num_voxels_i = '0;
  logic [7:0]  voxel_addr_o;
  logic [31:0] voxel_rdata_i = '0;
  logic [7:0]  palette_addr_o;
  logic [7:0]  palette_rdata_i = '0;
  logic [7:0]  voxel_x_o, voxel_y_o, voxel_z_o, voxel_id_o, palette_entry_o;
  logic        do_rasterize_o, do_shade_o;
  logic        rasterizing_done_i = 1'b0, shading_done_i = 1'b0;
  logic [7:0]  row_o, col_o;
  logic [7:0]  pixel_i = '0;
  logic        fb_valid_o;
  logic        fb_ready_i = 1'b1;
  logic [15:0] fb_addr_o;
  logic [7:0]  fb_data_o;
  logic        busy_o, frame_done_o;

  logic [31:0] vram [256];
  logic [7:0]  pram [256];
  logic [7:0]  pix_seed;
  logic        any_out;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    voxel_rdata_i   <= vram[voxel_addr_o];
    palette_rdata_i <= pram[palette_addr_o];
  end

  assign any_out = |{voxel_addr_o, palette_addr_o, voxel_x_o, voxel_y_o, voxel_z_o,
                     voxel_id_o, palette_entry_o, do_rasterize_o, do_shade_o, row_o, col_o,
                     fb_valid_o, fb_addr_o, fb_data_o, busy_o, frame_done_o};

  frame_sequencer #(
    .COORD_BITS(8), .PALETTE_BITS(8), .PIXEL_BITS(8), .ROW_BITS(8), .COL_BITS(8),
    .NUM_ROWS(NR), .NUM_COLS(NC), .VOXEL_ADDR_BITS(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .num_voxels_i(num_voxels_i),
    .voxel_addr_o(voxel_addr_o), .voxel_rdata_i(voxel_rdata_i),
    .palette_addr_o(palette_addr_o), .palette_rdata_i(palette_rdata_i),
    .voxel_x_o(voxel_x_o), .voxel_y_o(voxel_y_o), .voxel_z_o(voxel_z_o),
    .voxel_id_o(voxel_id_o), .palette_entry_o(palette_entry_o),
    .do_rasterize_o(do_rasterize_o), .do_shade_o(do_shade_o),
    .rasterizing_done_i(rasterizing_done_i), .shading_done_i(shading_done_i),
    .row_o(row_o), .col_o(col_o), .pixel_i(pixel_i),
    .fb_valid_o(fb_valid_o), .fb_ready_i(fb_ready_i), .fb_addr_o(fb_addr_o),
    .fb_data_o(fb_data_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  function automatic logic [7:0] pix_of(input logic [7:0] r, input logic [7:0] c);
    return (r * 8'd37) + (c * 8'd11) + pix_seed;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) begin
      vram[i] = $urandom;
      pram[i] = 8'($urandom);
    end
    pix_seed = 8'($urandom);
  endtask

  // Runs one frame cycle by cycle at the falling edge, acting as shader array and framebuffer.
  task automatic run_frame(input int n, input int fixed_dly, input bit noise, input bit stall,
                           input bit start_in_shade, input int abort_cyc);
    int cyc, ri, si, w, age, cur_dly, stall_cnt, r, c;
    bit rdone_sent, sdone_sent, hs_sent, finished, rast_started, shade_started;
    cyc = 0; ri = 0; si = 0; w = 0; age = 0; cur_dly = 0; stall_cnt = 0;
    rdone_sent = 0; sdone_sent = 0; hs_sent = 0; finished = 0;
    rast_started = 0; shade_started = 0;
    @(negedge clk);
    start_i = 1'b1;
    num_voxels_i = 8'(n);
    @(negedge clk);
    while (!finished && cyc < 10000) begin
      start_i = 1'b0;
      num_voxels_i = 8'($urandom);
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        n_checks++;
        if (do_rasterize_o !== 1'b1) $display("FAIL abort_in_rast got %b want 1", do_rasterize_o);
        else n_pass++;
        rst_i = 1'b1;
        rasterizing_done_i = 1'b0;
        shading_done_i = 1'b0;
        #1;
        n_checks++;
        if (any_out !== 1'b0) $display("FAIL reset_async_outputs got %b want 0", any_out);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (any_out !== 1'b0) $display("FAIL reset_held_outputs got %b want 0", any_out);
        else n_pass++;
        rst_i = 1'b0;
        @(negedge clk);
        return;
      end
      if (cyc == 0) begin
        n_checks++;
        if (busy_o !== 1'b1) $display("FAIL busy_after_start got %b want 1", busy_o);
        else n_pass++;
      end
      if (rdone_sent) begin
        ri++; age = 0; rdone_sent = 0;
        n_checks++;
        if (do_rasterize_o !== (ri < n)) $display("FAIL rast_after_done got %b want %b", do_rasterize_o, ri < n);
        else n_pass++;
      end
      if (sdone_sent) begin
        si++; age = 0; sdone_sent = 0;
        n_checks++;
        if (do_shade_o !== (si < NPAL)) $display("FAIL shade_after_done got %b want %b", do_shade_o, si < NPAL);
        else n_pass++;
      end
      if (hs_sent) begin
        w++; hs_sent = 0;
        n_checks++;
        if (fb_valid_o !== 1'b0) $display("FAIL fb_valid_after_hs got %b want 0", fb_valid_o);
        else n_pass++;
      end
      if (do_rasterize_o && !rast_started) begin
        rast_started = 1;
        n_checks++;
        if (!(n > 0 && cyc == 3)) $display("FAIL rast_rise_cycle got %0d want 3 (n=%0d)", cyc, n);
        else n_pass++;
      end
      if (do_shade_o && !shade_started) begin
        shade_started = 1;
        n_checks++;
        if (!(ri == n && (n > 0 || cyc == 3))) $display("FAIL shade_rise got cyc %0d ri %0d want ri %0d", cyc, ri, n);
        else n_pass++;
      end
      rasterizing_done_i = 1'b0;
      shading_done_i = 1'b0;
      if (do_rasterize_o) begin
        n_checks++;
        if (ri >= n || {voxel_x_o, voxel_y_o, voxel_z_o, voxel_id_o} !== vram[ri])
          $display("FAIL voxel_rec got %h want %h (idx %0d)", {voxel_x_o, voxel_y_o, voxel_z_o, voxel_id_o}, vram[ri], ri);
        else n_pass++;
        if (age == 0) cur_dly = (fixed_dly > 0) ? fixed_dly : $urandom_range(2, 8);
        age++;
        if (age == cur_dly) begin
          rasterizing_done_i = 1'b1;
          rdone_sent = 1;
        end
      end else if (noise) rasterizing_done_i = 1'($urandom);
      if (do_shade_o) begin
        n_checks++;
        if (si >= NPAL || voxel_id_o !== 8'(si) || palette_entry_o !== pram[si])
          $display("FAIL shade_entry got id %h pal %h want id %h pal %h", voxel_id_o, palette_entry_o, 8'(si), pram[si]);
        else n_pass++;
        if (age == 0) cur_dly = (fixed_dly > 0) ? fixed_dly : $urandom_range(2, 8);
        age++;
        if (start_in_shade && si == 10 && age == 1) start_i = 1'b1;
        if (age == cur_dly) begin
          shading_done_i = 1'b1;
          sdone_sent = 1;
        end
      end else if (noise) shading_done_i = 1'($urandom);
      pixel_i = pix_of(row_o, col_o);
      fb_ready_i = 1'b1;
      if (fb_valid_o) begin
        r = w / NC;
        c = w % NC;
        n_checks++;
        if (w >= NR*NC || si != NPAL || fb_addr_o !== {8'(r), 8'(c)} || fb_data_o !== pix_of(8'(r), 8'(c)))
          $display("FAIL fb_write got addr %h data %h want addr %h data %h (write %0d)",
                   fb_addr_o, fb_data_o, {8'(r), 8'(c)}, pix_of(8'(r), 8'(c)), w);
        else n_pass++;
        if (stall && w == 3 && stall_cnt < 5) begin
          fb_ready_i = 1'b0;
          stall_cnt++;
        end else hs_sent = 1;
      end
      if (frame_done_o) begin
        finished = 1;
        n_checks++;
        if (w != NR*NC) $display("FAIL writes_at_done got %0d want %0d", w, NR*NC);
        else n_pass++;
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!finished) $display("FAIL frame_timeout got %0d cycles want frame_done", cyc);
    else n_pass++;
    n_checks++;
    if (frame_done_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL after_done got done %b busy %b want 0 0", frame_done_o, busy_o);
    else n_pass++;
    if (stall) begin
      n_checks++;
      if (stall_cnt != 5) $display("FAIL stall_cycles got %0d want 5", stall_cnt);
      else n_pass++;
    end
    if (start_in_shade) begin
      repeat (5) @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b0 || do_rasterize_o !== 1'b0)
        $display("FAIL start_in_shade_ignored got busy %b rast %b want 0 0", busy_o, do_rasterize_o);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if (any_out !== 1'b0) $display("FAIL reset_state got %b want 0", any_out);
    else n_pass++;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL idle_busy got %b want 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_two_voxels();
    fill_mem();
    vram[0] = {8'd1, 8'd2, 8'd3, 8'd5};
    vram[1] = {8'd4, 8'd5, 8'd6, 8'd7};
    run_frame(2, 6, 0, 0, 0, 0);
  endtask

  task automatic test_zero_voxels();
    fill_mem();
    run_frame(0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_random_frame();
    fill_mem();
    run_frame($urandom_range(1, 12), 0, 1, 0, 0, 0);
  endtask

  task automatic test_fb_stall();
    fill_mem();
    run_frame(3, 0, 0, 1, 0, 0);
  endtask

  task automatic test_start_during_shade();
    fill_mem();
    run_frame(2, 4, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid_frame();
    fill_mem();
    run_frame(3, 6, 0, 0, 0, 12);
    n_checks++;
    if (busy_o !== 1'b0 || fb_valid_o !== 1'b0) $display("FAIL post_reset_idle got busy %b fbv %b want 0 0", busy_o, fb_valid_o);
    else n_pass++;
    run_frame(3, 0, 1, 0, 0, 0);
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_two_voxels();
    test_zero_voxels();
    test_random_frame();
    test_fb_stall();
    test_start_during_shade();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
